// File: rtl/wb_master_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_loader_if
// Purpose  : Wishbone write-bus bundle between the loader and the GPU IO slave.
// Revision : 1.0
// ============================================================================
interface wb_master_loader_if #(
  parameter int WB_WIDTH = 32
);
  logic                CYC_O;
  logic                STB_O;
  logic                WE_O;
  logic                MST_O;
  logic [WB_WIDTH-1:0] ADR_O;
  logic [WB_WIDTH-1:0] DAT_O;
  logic [1:0]          TGA_O;
  logic                ACK_I;

  modport master (
    output CYC_O, STB_O, WE_O, MST_O, ADR_O, DAT_O, TGA_O,
    input  ACK_I
  );

  modport slave (
    input  CYC_O, STB_O, WE_O, MST_O, ADR_O, DAT_O, TGA_O,
    output ACK_I
  );
endinterface
`default_nettype wire

// File: rtl/wb_master_loader.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_loader
// Purpose  : Replays host {tag, address, data} requests as single Wishbone
//            writes, holding CYC across consecutive same-tag words.
//            Optional ACK timeout enabled by defining WBM_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module wb_master_loader #(
  parameter int WB_WIDTH       = 32,
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                iPushValid,
  input  logic [WB_WIDTH-1:0] iPushAddress,
  input  logic [WB_WIDTH-1:0] iPushData,
  input  logic [1:0]          iPushTag,
  output logic                oPushReady,
  output logic [FIFO_AW:0]    oCount,
  output logic                oBusy,
  output logic                oError,
  input  logic                iClearError,
  wb_master_loader_if.master  wb
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int ENTRY_W = 2 * WB_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Request FIFO
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic                full, empty, push, pop;
  logic [ENTRY_W-1:0]  head;
  logic [1:0]          head_tag;
  logic [WB_WIDTH-1:0] head_adr;
  logic [WB_WIDTH-1:0] head_dat;

  // Bus-side registers
  state_t              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic [WB_WIDTH-1:0] adr_q, adr_d;
  logic [WB_WIDTH-1:0] dat_q, dat_d;
  logic [1:0]          tga_q, tga_d;

  assign full       = (count_q == (FIFO_AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = iPushValid & ~full;
  assign oPushReady = ~full;
  assign oCount     = count_q;

  assign head     = mem_q[rd_ptr_q];
  assign head_tag = head[ENTRY_W-1 -: 2];
  assign head_adr = head[2*WB_WIDTH-1 -: WB_WIDTH];
  assign head_dat = head[WB_WIDTH-1:0];

  always_ff @(posedge CLK_I) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {iPushTag, iPushAddress, iPushData};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef WBM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             error_q, error_d;
  logic             err_set;

  // A timeout in the same cycle as a clear must win.
  assign error_d = (error_q & ~iClearError) | err_set;
  assign oError  = error_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
    end
  end
`else
  // Constant 0; the reference keeps the timeout-only inputs attached.
  assign oError = iClearError & (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    tga_d   = tga_q;
    pop     = 1'b0;
`ifdef WBM_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_set    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          adr_d   = head_adr;
          dat_d   = head_dat;
          tga_d   = head_tag;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = S_WAIT;
`ifdef WBM_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end

      S_WAIT: begin
        if (wb.ACK_I) begin
          pop     = 1'b1;
          stb_d   = 1'b0;
          state_d = S_GAP;
`ifdef WBM_TIMEOUT_EN
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up on this word: drop it and close the cycle.
          pop     = 1'b1;
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          err_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
        end
      end

      S_GAP: begin
        // Same-tag successor continues the open cycle; anything else closes it.
        if (!empty && (head_tag == tga_q)) begin
          adr_d   = head_adr;
          dat_d   = head_dat;
          stb_d   = 1'b1;
          state_d = S_WAIT;
`ifdef WBM_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          cyc_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      tga_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      tga_q    <= tga_d;
    end
  end

  assign wb.CYC_O = cyc_q;
  assign wb.STB_O = stb_q;
  assign wb.WE_O  = cyc_q;
  assign wb.MST_O = cyc_q;
  assign wb.ADR_O = adr_q;
  assign wb.DAT_O = dat_q;
  assign wb.TGA_O = tga_q;

  assign oBusy = ~empty | cyc_q;

endmodule
`default_nettype wire
